// File: rtl/blink_game_ctrl.sv
// Game sequencer for the LED blink game: walks a one-hot light across the
// LED bar on each rising edge of the divided blink clock, judges player
// presses against a target LED and keeps the score that drives the divider.
// Button and start inputs are single-cycle pulses; there is no handshake.
module blink_game_ctrl #(
  parameter int NUM_LEDS    = 16,
  parameter int TARGET_IDX  = 8,
  parameter int MAX_SCORE   = 10,
  parameter int FLASH_TICKS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sclk,
  input  logic                start,
  input  logic                btn,
  output logic [3:0]          score,
  output logic [NUM_LEDS-1:0] led,
  output logic                playing,
  output logic                win
);

  localparam int PW = $clog2(NUM_LEDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_HIT,
    S_MISS,
    S_WIN
  } state_t;

  state_t        state, nxt_state;
  logic [PW-1:0] pos, nxt_pos;
  logic [3:0]    flash_cnt, nxt_flash;
  logic [3:0]    nxt_score;
  logic [NUM_LEDS-1:0] nxt_led;
  logic          sclk_q;
  logic          tick;

  localparam logic [PW-1:0] LAST_POS   = PW'(NUM_LEDS - 1);
  localparam logic [PW-1:0] TARGET_POS = PW'(TARGET_IDX);
  localparam logic [3:0]    MAX_S      = 4'(MAX_SCORE);
  localparam logic [3:0]    LAST_FLASH = 4'(FLASH_TICKS - 1);

  function automatic logic [NUM_LEDS-1:0] one_hot(input logic [PW-1:0] idx);
    logic [NUM_LEDS-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // One step pulse per rising edge of the blink clock.
  assign tick = sclk & ~sclk_q;

  // Next-state, score, position and LED pattern; LEDs are computed from the
  // next state so the registered bar always matches the registered state.
  always_comb begin
    nxt_state = state;
    nxt_pos   = pos;
    nxt_flash = flash_cnt;
    nxt_score = score;
    nxt_led   = '0;
    case (state)
      S_IDLE: begin
        if (start) begin
          nxt_state = S_RUN;
          nxt_pos   = '0;
          nxt_score = '0;
        end
      end
      S_RUN: begin
        // A press takes priority over a step in the same cycle: the light is
        // judged where the player saw it and does not move.
        if (btn) begin
          nxt_flash = '0;
          if (pos == TARGET_POS) begin
            nxt_score = score + 4'd1;
            nxt_state = (score + 4'd1 == MAX_S) ? S_WIN : S_HIT;
          end else begin
            nxt_score = (score == 4'd0) ? 4'd0 : score - 4'd1;
            nxt_state = S_MISS;
          end
        end else if (tick) begin
          nxt_pos = (pos == LAST_POS) ? '0 : pos + 1'b1;
        end
      end
      S_HIT, S_MISS: begin
        if (tick) begin
          if (flash_cnt == LAST_FLASH) begin
            nxt_state = S_RUN;
            nxt_pos   = '0;
            nxt_flash = '0;
          end else begin
            nxt_flash = flash_cnt + 4'd1;
          end
        end
      end
      S_WIN: begin
        if (start) begin
          nxt_state = S_RUN;
          nxt_pos   = '0;
          nxt_score = '0;
        end
      end
      default: nxt_state = S_IDLE;
    endcase

    case (nxt_state)
      S_RUN:   nxt_led = one_hot(nxt_pos);
      S_HIT:   nxt_led = nxt_flash[0] ? '0 : '1;
      S_MISS:  nxt_led = one_hot(TARGET_POS);
      S_WIN:   nxt_led = '1;
      default: nxt_led = '0;
    endcase
  end

  // Game FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pos       <= '0;
      flash_cnt <= '0;
      score     <= '0;
      led       <= '0;
      playing   <= 1'b0;
      win       <= 1'b0;
      sclk_q    <= 1'b0;
    end else begin
      sclk_q    <= sclk;
      state     <= nxt_state;
      pos       <= nxt_pos;
      flash_cnt <= nxt_flash;
      score     <= nxt_score;
      led       <= nxt_led;
      playing   <= (nxt_state == S_RUN) || (nxt_state == S_HIT) ||
                   (nxt_state == S_MISS);
      win       <= (nxt_state == S_WIN);
    end
  end

endmodule

// File: tb/tb_blink_game_ctrl.sv
// Bench for blink_game_ctrl: directed game scenarios followed by random
// play, every cycle compared against a behavioural model of the game rules.
module tb_blink_game_ctrl;

  localparam int NUM_LEDS    = 16;
  localparam int TARGET_IDX  = 8;
  localparam int MAX_SCORE   = 10;
  localparam int FLASH_TICKS = 4;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HIT  = 2;
  localparam int M_MISS = 3;
  localparam int M_WIN  = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk = 1'b0;
  logic start = 1'b0;
  logic btn = 1'b0;
  logic [3:0] score;
  logic [NUM_LEDS-1:0] led;
  logic playing;
  logic win;

  always #5 clk = ~clk;

  blink_game_ctrl #(
    .NUM_LEDS(NUM_LEDS), .TARGET_IDX(TARGET_IDX),
    .MAX_SCORE(MAX_SCORE), .FLASH_TICKS(FLASH_TICKS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .start(start), .btn(btn),
    .score(score), .led(led), .playing(playing), .win(win)
  );

  // ---------------- scoreboard ----------------
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_mode = M_IDLE;
  int m_pos = 0;
  int m_score = 0;
  int m_flash = 0;
  bit m_sq = 1'b0;

  function automatic logic [NUM_LEDS-1:0] model_led();
    logic [NUM_LEDS-1:0] e;
    e = '0;
    case (m_mode)
      M_RUN:  e[m_pos] = 1'b1;
      M_HIT:  e = (m_flash % 2 == 0) ? '1 : '0;
      M_MISS: e[TARGET_IDX] = 1'b1;
      M_WIN:  e = '1;
      default: e = '0;
    endcase
    return e;
  endfunction

  task automatic model_step(input logic s, input logic st, input logic b,
                            input logic r);
    bit tk;
    if (!r) begin
      m_mode = M_IDLE; m_score = 0; m_pos = 0; m_flash = 0; m_sq = 1'b0;
    end else begin
      tk = s && !m_sq;
      m_sq = s;
      if (m_mode == M_IDLE || m_mode == M_WIN) begin
        if (st) begin
          m_mode = M_RUN; m_pos = 0; m_score = 0;
        end
      end else if (m_mode == M_RUN) begin
        if (b) begin
          m_flash = 0;
          if (m_pos == TARGET_IDX) begin
            m_score = m_score + 1;
            m_mode = (m_score == MAX_SCORE) ? M_WIN : M_HIT;
          end else begin
            m_score = (m_score > 0) ? m_score - 1 : 0;
            m_mode = M_MISS;
          end
        end else if (tk) begin
          m_pos = (m_pos + 1) % NUM_LEDS;
        end
      end else if (tk) begin
        // HIT or MISS: the display lasts FLASH_TICKS steps in total.
        m_flash = m_flash + 1;
        if (m_flash == FLASH_TICKS) begin
          m_mode = M_RUN; m_pos = 0; m_flash = 0;
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic s, input logic st, input logic b,
                      input logic r);
    sclk = s; start = st; btn = b; rst_n = r;
    @(posedge clk);
    model_step(s, st, b, r);
    #1;
    check("score", 32'(score), 32'(m_score));
    check("led", 32'(led), 32'(model_led()));
    check("playing", 32'(playing),
          32'(m_mode == M_RUN || m_mode == M_HIT || m_mode == M_MISS));
    check("win", 32'(win), 32'(m_mode == M_WIN));
    start = 1'b0; btn = 1'b0;
  endtask

  task automatic sclk_edge();
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic goto_pos(input int p);
    logic [NUM_LEDS-1:0] e;
    for (int i = 0; i < 2 * NUM_LEDS && m_pos != p; i++) sclk_edge();
    e = '0;
    e[p] = 1'b1;
    check("goto_pos", 32'(led), 32'(e));
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_start();
    step(1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  // Score one point and sit out the feedback display (unless the game ends).
  task automatic hit_once();
    goto_pos(TARGET_IDX);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    if (m_mode != M_WIN)
      for (int i = 0; i < FLASH_TICKS; i++) sclk_edge();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic cur_s;

    // Reset held while sclk toggles and start pulses.
    for (int i = 0; i < 3; i++) step(1'(i % 2), 1'b1, 1'b0, 1'b0);
    check("rst_score", 32'(score), 32'd0);
    check("rst_led", 32'(led), 32'd0);
    check("rst_playing", 32'(playing), 32'd0);
    check("rst_win", 32'(win), 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check("idle_after_rst", 32'(playing), 32'd0);

    // Light walks and wraps.
    do_start();
    for (int i = 0; i < 5; i++) sclk_edge();
    check("run_pos5", 32'(led), 32'h0020);
    check("run_playing", 32'(playing), 32'd1);
    for (int i = 0; i < 11; i++) sclk_edge();
    check("run_wrap", 32'(led), 32'h0001);

    // Hit at score 3 and the flash sequence.
    for (int i = 0; i < 3; i++) hit_once();
    goto_pos(TARGET_IDX);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check("hit_score", 32'(score), 32'd4);
    check("hit_led0", 32'(led), 32'hFFFF);
    sclk_edge(); check("hit_led1", 32'(led), 32'h0000);
    sclk_edge(); check("hit_led2", 32'(led), 32'hFFFF);
    sclk_edge(); check("hit_led3", 32'(led), 32'h0000);
    sclk_edge(); check("hit_back_run", 32'(led), 32'h0001);
    check("hit_back_playing", 32'(playing), 32'd1);

    // Misses: saturation at 0 and decrement.
    do_reset(); do_start();
    goto_pos(5);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check("miss_sat", 32'(score), 32'd0);
    check("miss_led", 32'(led), 32'h0100);
    for (int i = 0; i < FLASH_TICKS; i++) begin
      check("miss_steady", 32'(led), 32'h0100);
      sclk_edge();
    end
    check("miss_back_run", 32'(led), 32'h0001);
    hit_once(); hit_once();
    goto_pos(5);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check("miss_dec", 32'(score), 32'd1);
    for (int i = 0; i < FLASH_TICKS; i++) sclk_edge();

    // Press and step together: press wins, light holds.
    goto_pos(TARGET_IDX);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    check("btn_tick_score", 32'(score), 32'd2);
    check("btn_tick_pos", 32'(dut.pos), 32'(TARGET_IDX));
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < FLASH_TICKS; i++) sclk_edge();

    // Ten hits win the game; presses are then ignored; start restarts.
    do_reset(); do_start();
    for (int i = 0; i < MAX_SCORE; i++) hit_once();
    check("win_score", 32'(score), 32'(MAX_SCORE));
    check("win_flag", 32'(win), 32'd1);
    check("win_led", 32'(led), 32'hFFFF);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    sclk_edge();
    check("win_hold", 32'(score), 32'(MAX_SCORE));
    do_start();
    check("restart_score", 32'(score), 32'd0);
    check("restart_playing", 32'(playing), 32'd1);
    check("restart_win", 32'(win), 32'd0);

    // Reset during HIT aborts the game.
    for (int i = 0; i < 5; i++) hit_once();
    goto_pos(TARGET_IDX);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check("pre_abort_score", 32'(score), 32'd6);
    sclk_edge();
    do_reset();
    check("abort_score", 32'(score), 32'd0);
    check("abort_led", 32'(led), 32'd0);
    check("abort_flash", 32'(dut.flash_cnt), 32'd0);
    check("abort_playing", 32'(playing), 32'd0);

    // Random play.
    cur_s = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 2) == 0) cur_s = ~cur_s;
      step(cur_s, 1'($urandom_range(0, 39) == 0),
           1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 599) != 0));
    end
    // Random play biased toward target presses to reach high scores.
    do_reset(); do_start();
    for (int i = 0; i < 60; i++) begin
      if (m_mode == M_RUN && $urandom_range(0, 3) != 0) goto_pos(TARGET_IDX);
      else if (m_mode == M_WIN) do_start();
      step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
      for (int j = 0; j < int'($urandom_range(0, 5)); j++) sclk_edge();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
